triangle_checker: RTL and testbench

TRIANGLE_CHECKER -- requirements
Module: triangle_checker

---
 rtl/triangle_checker.sv | 138 +++++++++++++
 tb/tb_triangle_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/triangle_checker.sv
// Conformance checker for an unsigned triangle wave with one-sample holds at peak and trough.
// Tracks lock, direction, measured period and a saturating error count.
module triangle_checker #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic             locked,
   output logic             dir,
   output logic             peak_pulse,
   output logic             trough_pulse,
   output logic             err_pulse,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [WIDTH-1:0] PEAK    = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      RISING  = 2'd1,
      FALLING = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             locked_q, locked_d;
   logic             dir_q, dir_d;
   logic             peak_q, peak_d;
   logic             trough_q, trough_d;
   logic             err_q, err_d;
   logic             err_c;
   logic [CNT_W-1:0] cnt_inc_c;

   assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state: step the expected wave one valid sample at a time
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      err_count_d = err_count_q;
      locked_d    = locked_q;
      peak_d      = 1'b0;
      trough_d    = 1'b0;
      err_d       = 1'b0;
      err_c       = 1'b0;
      if (sample_valid) begin
         prev_d = sample;
         case (state_q)
            ACQUIRE: begin
               if (sample == WIDTH'(1) && prev_q == '0) begin
                  state_d = RISING;
                  cnt_d   = CNT_W'(2);
               end
            end
            RISING: begin
               if (prev_q != PEAK) begin
                  if (sample == prev_q + WIDTH'(1)) cnt_d = cnt_inc_c;
                  else                              err_c = 1'b1;
               end else if (sample == PEAK) begin
                  state_d = FALLING;
                  peak_d  = 1'b1;
                  cnt_d   = cnt_inc_c;
               end else begin
                  err_c = 1'b1;
               end
            end
            FALLING: begin
               if (prev_q != '0) begin
                  if (sample == prev_q - WIDTH'(1)) cnt_d = cnt_inc_c;
                  else                              err_c = 1'b1;
               end else if (sample == '0) begin
                  // Trough hold: the first one after acquisition only establishes lock
                  state_d  = RISING;
                  trough_d = 1'b1;
                  cnt_d    = CNT_W'(1);
                  if (locked_q) period_d = cnt_q;
                  locked_d = 1'b1;
               end else begin
                  err_c = 1'b1;
               end
            end
            default: state_d = ACQUIRE;
         endcase
         if (err_c) begin
            state_d     = ACQUIRE;
            err_d       = 1'b1;
            locked_d    = 1'b0;
            err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CNT_W'(1);
         end
      end
      dir_d = (state_d == RISING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACQUIRE;
         prev_q      <= '0;
         cnt_q       <= '0;
         period_q    <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         dir_q       <= 1'b0;
         peak_q      <= 1'b0;
         trough_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         dir_q       <= dir_d;
         peak_q      <= peak_d;
         trough_q    <= trough_d;
         err_q       <= err_d;
      end
   end

   assign locked       = locked_q;
   assign dir          = dir_q;
   assign peak_pulse   = peak_q;
   assign trough_pulse = trough_q;
   assign err_pulse    = err_q;
   assign period       = period_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_triangle_checker.sv
// Directed bench for triangle_checker with default parameters (WIDTH=5, CNT_W=8).
module tb_triangle_checker;

   logic       clk;
   logic       rst_n;
   logic       sample_valid;
   logic [4:0] sample;
   logic       locked, dir, peak_pulse, trough_pulse, err_pulse;
   logic [7:0] period, err_count;

   int tests = 0;
   int fails = 0;
   int multi_hot = 0;

   triangle_checker #(.WIDTH(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
      .locked(locked), .dir(dir), .peak_pulse(peak_pulse), .trough_pulse(trough_pulse),
      .err_pulse(err_pulse), .period(period), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && (int'(peak_pulse) + int'(trough_pulse) + int'(err_pulse)) > 1) multi_hot++;

   // Ideal wave: position m of a 64-sample period, m=0 is the trough hold
   function automatic logic [4:0] wave(input int n);
      int m;
      m = n % 64;
      if (m <= 31)      return 5'(m);
      else if (m == 32) return 5'd31;
      else              return 5'(63 - m);
   endfunction

   task automatic drive(input logic v, input logic [4:0] s);
      sample_valid = v;
      sample       = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sample_valid = 1'b0;
      sample       = '0;
      rst_n        = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir: got %b want 0", dir); end
      tests++; if ({peak_pulse, trough_pulse, err_pulse} !== 3'b000) begin fails++;
         $display("FAIL reset_pulses: got %b want 000", {peak_pulse, trough_pulse, err_pulse}); end
      tests++; if (period !== 8'd0) begin fails++; $display("FAIL reset_period: got %0d want 0", period); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Wave 0,0,1..31,31,30..0,... from reset; lock at first trough after acquisition
   task automatic test_ideal();
      int pk = 0, tr = 0, er = 0;
      for (int n = 63; n <= 256; n++) begin
         drive(1'b1, wave(n));
         pk += int'(peak_pulse); tr += int'(trough_pulse); er += int'(err_pulse);
         if (n == 64) begin tests++; if (dir !== 1'b0 || locked !== 1'b0) begin fails++;
            $display("FAIL ideal_acquire: dir=%b locked=%b want 0 0", dir, locked); end end
         if (n == 65) begin tests++; if (dir !== 1'b1) begin fails++; $display("FAIL ideal_rise_dir: got %b want 1", dir); end end
         if (n == 96) begin tests++; if (peak_pulse !== 1'b1 || dir !== 1'b0) begin fails++;
            $display("FAIL ideal_peak: peak=%b dir=%b want 1 0", peak_pulse, dir); end end
         if (n == 127) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL ideal_prelock: got %b want 0", locked); end end
         if (n == 128) begin tests++; if (trough_pulse !== 1'b1 || locked !== 1'b1 || period !== 8'd0) begin fails++;
            $display("FAIL ideal_first_trough: trough=%b locked=%b period=%0d want 1 1 0", trough_pulse, locked, period); end end
         if (n == 192) begin tests++; if (period !== 8'd64) begin fails++; $display("FAIL ideal_period: got %0d want 64", period); end end
      end
      tests++; if (pk != 3 || tr != 3 || er != 0) begin fails++;
         $display("FAIL ideal_pulse_counts: peaks=%0d troughs=%0d errs=%0d want 3 3 0", pk, tr, er); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL ideal_err_count: got %0d want 0", err_count); end
   endtask

   // 12 after 10 while rising; relock one trough after re-acquisition
   task automatic test_err_rising();
      int b = 256, er = 0;
      for (int n = b + 1; n <= b + 10; n++) drive(1'b1, wave(n));
      drive(1'b1, 5'd12);
      tests++; if (err_pulse !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || dir !== 1'b0) begin fails++;
         $display("FAIL rise_err: err=%b locked=%b cnt=%0d dir=%b want 1 0 1 0", err_pulse, locked, err_count, dir); end
      for (int n = b + 13; n <= b + 128; n++) begin
         drive(1'b1, wave(n));
         er += int'(err_pulse);
         if (n == b + 127) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rise_prelock: got %b want 0", locked); end end
         if (n == b + 128) begin tests++; if (locked !== 1'b1 || trough_pulse !== 1'b1 || period !== 8'd64) begin fails++;
            $display("FAIL rise_relock: locked=%b trough=%b period=%0d want 1 1 64", locked, trough_pulse, period); end end
      end
      tests++; if (er != 0 || err_count !== 8'd1) begin fails++;
         $display("FAIL rise_recover_errs: pulses=%0d cnt=%0d want 0 1", er, err_count); end
   endtask

   // Invalid cycles mid-ramp with junk samples are ignored
   task automatic test_valid_gap();
      int b = 384;
      for (int n = b + 1; n <= b + 15; n++) drive(1'b1, wave(n));
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 5'($urandom_range(31)));
         tests++; if (err_pulse !== 1'b0 || locked !== 1'b1 || dir !== 1'b1) begin fails++;
            $display("FAIL gap_idle: err=%b locked=%b dir=%b want 0 1 1", err_pulse, locked, dir); end
      end
      for (int n = b + 16; n <= b + 128; n++) begin
         drive(1'b1, wave(n));
         if (n == b + 64 || n == b + 128) begin tests++; if (trough_pulse !== 1'b1 || period !== 8'd64) begin fails++;
            $display("FAIL gap_period: trough=%b period=%0d want 1 64", trough_pulse, period); end end
      end
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL gap_err_count: got %0d want 1", err_count); end
   endtask

   // Missing peak hold, then missing trough hold
   task automatic test_no_hold();
      int b = 512;
      for (int n = b + 1; n <= b + 31; n++) drive(1'b1, wave(n));
      drive(1'b1, 5'd30);
      tests++; if (err_pulse !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0) begin fails++;
         $display("FAIL peak_nohold: err=%b cnt=%0d locked=%b want 1 2 0", err_pulse, err_count, locked); end
      for (int n = b + 34; n <= b + 127; n++) drive(1'b1, wave(n));
      tests++; if (err_pulse !== 1'b0 || dir !== 1'b0) begin fails++;
         $display("FAIL fall_to_zero: err=%b dir=%b want 0 0", err_pulse, dir); end
      drive(1'b1, 5'd1);
      tests++; if (err_pulse !== 1'b1 || err_count !== 8'd3) begin fails++;
         $display("FAIL trough_nohold: err=%b cnt=%0d want 1 3", err_pulse, err_count); end
   endtask

   // Stuck input gives one error; then err_count saturation
   task automatic test_const_and_saturate();
      int er = 0;
      int unsigned exp_cnt = 4;
      for (int n = 703; n <= 768; n++) drive(1'b1, wave(n));
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL const_lock: got %b want 1", locked); end
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 5'd7);
         er += int'(err_pulse);
      end
      tests++; if (er != 1 || err_count !== 8'd4 || locked !== 1'b0 || dir !== 1'b0) begin fails++;
         $display("FAIL const_seven: pulses=%0d cnt=%0d locked=%b dir=%b want 1 4 0 0", er, err_count, locked, dir); end
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 5'd0);
         drive(1'b1, 5'd1);
         drive(1'b1, 5'd5);
         exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
         tests++; if (err_count !== 8'(exp_cnt) || err_pulse !== 1'b1) begin fails++;
            $display("FAIL sat_step%0d: cnt=%0d err=%b want %0d 1", i, err_count, err_pulse, exp_cnt); end
      end
   endtask

   // Async reset while locked mid-fall, then relock from scratch
   task automatic test_reset_mid();
      for (int n = 767; n <= 877; n++) drive(1'b1, wave(n));
      tests++; if (locked !== 1'b1 || dir !== 1'b0 || period !== 8'd64) begin fails++;
         $display("FAIL mid_prereset: locked=%b dir=%b period=%0d want 1 0 64", locked, dir, period); end
      rst_n = 1'b0;
      #1;
      tests++; if ({locked, dir, peak_pulse, trough_pulse, err_pulse} !== 5'b0 || period !== 8'd0 || err_count !== 8'd0) begin fails++;
         $display("FAIL mid_reset: flags=%b period=%0d cnt=%0d want 00000 0 0",
                  {locked, dir, peak_pulse, trough_pulse, err_pulse}, period, err_count); end
      drive(1'b1, 5'd3);
      drive(1'b1, 5'd2);
      rst_n = 1'b1;
      for (int n = 878; n <= 960; n++) begin
         drive(1'b1, wave(n));
         if (n == 959) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_prelock: got %b want 0", locked); end end
         if (n == 960) begin tests++; if (locked !== 1'b1 || period !== 8'd0 || err_count !== 8'd0) begin fails++;
            $display("FAIL mid_relock: locked=%b period=%0d cnt=%0d want 1 0 0", locked, period, err_count); end end
      end
   endtask

   task automatic test_pulse_exclusive();
      tests++; if (multi_hot != 0) begin fails++; $display("FAIL pulse_exclusive: got %0d cycles want 0", multi_hot); end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_err_rising();
      test_valid_gap();
      test_no_hold();
      test_const_and_saturate();
      test_reset_mid();
      test_pulse_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
